dec_hazard_track: RTL and testbench
===================================

Name: dec_hazard_track

Overview:
- Parametrised successor to the decode-stage pause/forward logic.
- Tracks in-flight destination registers across a configurable number of downstream pipeline stages.
- Each stage is tagged with the stage at which its result becomes available (ALU or multi-cycle load).
- Per read port it either forwards the youngest ready result or raises a pause. Sits in DEC, between the register file read ports and the DEC/EX boundary.

Parameters:
- DW, 32: data width.
- AW, 5: register address width. Register 0 is hard-wired zero.
- NRP, 2: number of register read ports.
- DEPTH, 3: tracked downstream stages. Slot 0 = EX, slot DEPTH-1 = WB.
- LOAD_RDY, 1: slot index at which load data is valid. Range 0..DEPTH-1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_issueVld  in  1  DEC holds a valid instruction
- i_regWe  in  1  issuing instruction writes a register
- i_isLoad  in  1  issuing instruction is a load
- i_wa  in  AW  issuing instruction destination
- i_ra  in  NRP*AW  read addresses, port p at [p*AW +: AW]
- i_rfData  in  NRP*DW  register file read data per port
- i_stgData  in  DEPTH*DW  result data of slot k at [k*DW +: DW]
- i_hold  in  1  downstream freeze; table does not advance
- i_flush  in  1  kill the instruction in DEC
- o_pause  out  1  stall DEC and IF this cycle
- o_rd  out  NRP*DW  operand data per port
- o_fwdHit  out  NRP  port p takes a forwarded value

Behaviour:
- State: DEPTH slots, each holding {vld, wa, isLoad}. All vld=0 on reset (async, rstn low). While in reset: o_pause=0, o_fwdHit=0, o_rd=i_rfData.
- A slot matches port p when vld=1, wa==ra[p], and ra[p]!=0. Match is evaluated combinationally every cycle.
- Youngest match wins (lowest slot index k).
- The winning slot is ready if isLoad=0, or if k>=LOAD_RDY.
- Ready youngest match: o_rd[p]=i_stgData[k], o_fwdHit[p]=1.
- No match: o_rd[p]=i_rfData[p], o_fwdHit[p]=0. The register file writes at the end of the WB cycle and reads non-write-through, so slot DEPTH-1 must be forwarded.
- Youngest match not ready: o_pause=1. Older ready matches are never used in place of it.
- o_pause is gated by i_issueVld: when i_issueVld=0, o_pause=0.
- Advance on every clk edge with i_hold=0: slot k+1 <= slot k; slot DEPTH-1 is discarded.
- Slot 0 load on advance:
  - If i_issueVld & i_regWe & ~o_pause & ~i_flush: slot 0 <= {1, i_wa, i_isLoad}.
  - Otherwise slot 0 <= bubble (vld=0).
  - A write to register 0 is entered with vld=0.
- i_hold=1: all slots keep their values. Combinational outputs are still computed from the frozen table. i_flush is ignored for this cycle.
- Simultaneous i_flush and o_pause: flush wins and a bubble is inserted. o_pause is still reported.
- Pause latency: a load in slot 0 followed by a dependent instruction gives LOAD_RDY pause cycles, then forwards.
- Reset asserted mid-operation: the table clears immediately. No pending pause survives.

Optional Feature:
- Macro: DEC_HAZARD_FWD_EN.
- Defined: forwarding as described above.
- Undefined: no forwarding paths. Any match on any port raises o_pause until the slot leaves the table. o_rd is always i_rfData and o_fwdHit is always 0. The i_stgData inputs are unused.

Test Plan:
- Reset, then issue add r3 (regWe=1, isLoad=0, wa=3). Next cycle ra0=3, i_stgData slot0=0x0000_00AA -> o_rd0=0xAA, o_fwdHit=01, o_pause=0.
- Load r5 issued, next instruction reads r5 on port 1, LOAD_RDY=1 -> o_pause=1 for exactly 1 cycle. The cycle after, o_rd1=i_stgData slot1=0x1234_5678, o_fwdHit[1]=1.
- Two writes to r7 in slots 0 (value 0x2) and 1 (value 0x1), both ALU -> o_rd=0x2 (youngest).
- ra0=0 while slot0 has wa=0 issued -> o_rd0=i_rfData0, no pause. Flush on the load issue cycle, then a dependent read -> no pause.
- i_hold=1 for 3 cycles with a load in slot 0 and a dependent read -> o_pause stays 1 and the slot does not move. On release, the pause clears after LOAD_RDY advances.
- Macro undefined: ALU write r4 then read r4 -> o_pause=1 for DEPTH cycles, then o_rd0=i_rfData0.

Source files
------------

// File: rtl/dec_hazard_track.sv
// dec_hazard_track: DEC-stage tracker of in-flight destinations; forwards or pauses per read port.
// Forwarding muxes exist only with DEC_HAZARD_FWD_EN defined; otherwise any match pauses.
module dec_hazard_track #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_issueVld,
    input  logic               i_regWe,
    input  logic               i_isLoad,
    input  logic [AW-1:0]      i_wa,
    input  logic [NRP*AW-1:0]  i_ra,
    input  logic [NRP*DW-1:0]  i_rfData,
    input  logic [DEPTH*DW-1:0] i_stgData,
    input  logic               i_hold,
    input  logic               i_flush,
    output logic               o_pause,
    output logic [NRP*DW-1:0]  o_rd,
    output logic [NRP-1:0]     o_fwdHit
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]         vld_q, vld_d, ld_q, ld_d;
    logic [DEPTH-1:0][AW-1:0] wa_q, wa_d;
    logic [NRP-1:0]           hit, rdy, port_pause;
    logic [NRP-1:0][IW-1:0]   idx;
    logic                     issue_ok;

    always_comb begin
        hit = '0;
        idx = '0;
        rdy = '0;
        for (int p = 0; p < NRP; p++) begin
            // scan oldest to youngest so the youngest match overwrites
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (vld_q[k] && wa_q[k] == i_ra[p*AW +: AW] && i_ra[p*AW +: AW] != '0) begin
                    hit[p] = 1'b1;
                    idx[p] = IW'(k);
                end
            end
            rdy[p] = hit[p] && (!ld_q[idx[p]] || int'(idx[p]) >= LOAD_RDY);
        end
    end

`ifdef DEC_HAZARD_FWD_EN
    always_comb begin
        port_pause = '0;
        o_fwdHit   = '0;
        o_rd       = i_rfData;
        for (int p = 0; p < NRP; p++) begin
            port_pause[p] = hit[p] & ~rdy[p];
            if (rdy[p]) begin
                o_fwdHit[p]       = 1'b1;
                o_rd[p*DW +: DW]  = i_stgData[int'(idx[p])*DW +: DW];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_stgData, rdy};
    assign port_pause = hit;
    assign o_rd       = i_rfData;
    assign o_fwdHit   = '0;
`endif

    assign o_pause  = i_issueVld & (|port_pause);
    // a write to r0 never creates a hazard, so it enters as a bubble
    assign issue_ok = i_issueVld & i_regWe & ~o_pause & ~i_flush & (i_wa != '0);

    always_comb begin
        vld_d = vld_q;
        wa_d  = wa_q;
        ld_d  = ld_q;
        if (!i_hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                wa_d[k]  = wa_q[k-1];
                ld_d[k]  = ld_q[k-1];
            end
            vld_d[0] = issue_ok;
            wa_d[0]  = i_wa;
            ld_d[0]  = i_isLoad;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            wa_q  <= '0;
            ld_q  <= '0;
        end else begin
            vld_q <= vld_d;
            wa_q  <= wa_d;
            ld_q  <= ld_d;
        end
    end
endmodule

// File: tb/tb_dec_hazard_track.sv
// Directed table bench for dec_hazard_track (DEPTH=3, LOAD_RDY=1); expectations follow the
// build flavour selected by DEC_HAZARD_FWD_EN.
module tb_dec_hazard_track;
    localparam logic [31:0] RF0 = 32'h0000_0F0F;
    localparam logic [31:0] RF1 = 32'h1111_1111;
    localparam logic [31:0] S0  = 32'h0000_00AA;
    localparam logic [31:0] S1  = 32'h1234_5678;
    localparam logic [31:0] S2  = 32'hCCCC_0002;
    localparam int NV = 29;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iv, we, ld, hold, flush;
    logic [4:0]  wa, ra0, ra1;
    logic        o_pause;
    logic [63:0] o_rd;
    logic [1:0]  o_fwdHit;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dec_hazard_track dut (
        .clk(clk), .rstn(rstn),
        .i_issueVld(iv), .i_regWe(we), .i_isLoad(ld), .i_wa(wa),
        .i_ra({ra1, ra0}), .i_rfData({RF1, RF0}), .i_stgData({S2, S1, S0}),
        .i_hold(hold), .i_flush(flush),
        .o_pause(o_pause), .o_rd(o_rd), .o_fwdHit(o_fwdHit)
    );

    typedef struct {
        logic        iv, we, ld;
        logic [4:0]  wa, ra0, ra1;
        logic        hold, flush;
        logic        e_p;
        logic [1:0]  e_f;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t tbl [NV];

    // pf/ff/rd0f/rd1f: forwarding build; pn: pause in the no-forward build
    function automatic vec_t mk(input logic iv_, we_, ld_, input logic [4:0] wa_, ra0_, ra1_,
                                input logic hold_, flush_, pf, input logic [1:0] ff,
                                input logic [31:0] rd0f, rd1f, input logic pn);
        vec_t v;
        v.iv = iv_; v.we = we_; v.ld = ld_; v.wa = wa_; v.ra0 = ra0_; v.ra1 = ra1_;
        v.hold = hold_; v.flush = flush_;
`ifdef DEC_HAZARD_FWD_EN
        v.e_p = pf; v.e_f = ff; v.e_rd0 = rd0f; v.e_rd1 = rd1f;
`else
        v.e_p = pn; v.e_f = 2'b00; v.e_rd0 = RF0; v.e_rd1 = RF1;
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv_, we_, ld_, input logic [4:0] wa_, ra0_, ra1_,
                         input logic hold_, flush_);
        iv = iv_; we = we_; ld = ld_; wa = wa_; ra0 = ra0_; ra1 = ra1_;
        hold = hold_; flush = flush_;
    endtask

    initial begin
        //                iv we ld wa  ra0 ra1 hd fl | pf ff     rd0f rd1f | pn
        tbl[0]  = mk(0, 0, 0, 0,  3,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[1]  = mk(1, 1, 0, 3,  1,  2,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[2]  = mk(1, 0, 0, 0,  3,  0,  0, 0,  0, 2'b01, S0,  RF1, 1);
        tbl[3]  = mk(1, 0, 0, 0,  0,  3,  0, 0,  0, 2'b10, RF0, S1,  1);
        tbl[4]  = mk(1, 0, 0, 0,  3,  3,  0, 0,  0, 2'b11, S2,  S2,  1);
        tbl[5]  = mk(1, 0, 0, 0,  3,  3,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[6]  = mk(1, 1, 1, 5,  0,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[7]  = mk(1, 0, 0, 0,  0,  5,  0, 0,  1, 2'b00, RF0, RF1, 1);
        tbl[8]  = mk(1, 0, 0, 0,  0,  5,  0, 0,  0, 2'b10, RF0, S1,  1);
        tbl[9]  = mk(1, 0, 0, 0,  5,  0,  0, 0,  0, 2'b01, S2,  RF1, 1);
        tbl[10] = mk(1, 1, 0, 7,  0,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[11] = mk(1, 1, 0, 7,  0,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[12] = mk(1, 0, 0, 0,  7,  0,  0, 0,  0, 2'b01, S0,  RF1, 1);
        tbl[13] = mk(0, 0, 0, 0,  7,  7,  0, 0,  0, 2'b11, S1,  S1,  0);
        tbl[14] = mk(0, 0, 0, 0,  0,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[15] = mk(1, 1, 0, 0,  0,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[16] = mk(1, 1, 1, 9,  0,  0,  0, 1,  0, 2'b00, RF0, RF1, 0);
        tbl[17] = mk(1, 0, 0, 0,  9,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[18] = mk(1, 1, 0, 10, 0,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[19] = mk(1, 1, 0, 11, 10, 0,  0, 1,  0, 2'b01, S0,  RF1, 1);
        tbl[20] = mk(1, 0, 0, 0,  11, 10, 0, 0,  0, 2'b10, RF0, S1,  1);
        tbl[21] = mk(1, 0, 0, 0,  11, 0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[22] = mk(1, 1, 1, 12, 0,  0,  0, 0,  0, 2'b00, RF0, RF1, 0);
        tbl[23] = mk(1, 0, 0, 0,  0,  12, 1, 0,  1, 2'b00, RF0, RF1, 1);
        tbl[24] = mk(1, 0, 0, 0,  0,  12, 1, 0,  1, 2'b00, RF0, RF1, 1);
        tbl[25] = mk(1, 1, 0, 13, 13, 12, 1, 1,  1, 2'b00, RF0, RF1, 1);
        tbl[26] = mk(1, 0, 0, 0,  0,  12, 0, 0,  1, 2'b00, RF0, RF1, 1);
        tbl[27] = mk(1, 0, 0, 0,  0,  12, 0, 0,  0, 2'b10, RF0, S1,  1);
        tbl[28] = mk(1, 0, 0, 0,  13, 0,  0, 0,  0, 2'b00, RF0, RF1, 0);

        rstn = 1'b0;
        drive(1, 1, 0, 3, 3, 3, 0, 0);
        @(negedge clk);
        #2;
        chk("rst.pause", {31'd0, o_pause}, 32'd0);
        chk("rst.fwd",   {30'd0, o_fwdHit}, 32'd0);
        chk("rst.rd0",   o_rd[31:0], RF0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].we, tbl[i].ld, tbl[i].wa, tbl[i].ra0, tbl[i].ra1,
                  tbl[i].hold, tbl[i].flush);
            #2;
            chk($sformatf("v%0d.pause", i), {31'd0, o_pause}, {31'd0, tbl[i].e_p});
            chk($sformatf("v%0d.fwd", i), {30'd0, o_fwdHit}, {30'd0, tbl[i].e_f});
            chk($sformatf("v%0d.rd0", i), o_rd[31:0], tbl[i].e_rd0);
            chk($sformatf("v%0d.rd1", i), o_rd[63:32], tbl[i].e_rd1);
        end

        // async reset with a pending load hazard: pause must drop at once and not come back
        @(negedge clk);
        drive(1, 1, 1, 14, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 14, 0, 0, 0);
        #2;
        chk("mid.pause_before", {31'd0, o_pause}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("mid.pause_in_rst", {31'd0, o_pause}, 32'd0);
        chk("mid.fwd_in_rst", {30'd0, o_fwdHit}, 32'd0);
        chk("mid.rd0_in_rst", o_rd[31:0], RF0);
        @(negedge clk);
        rstn = 1'b1;
        #2;
        chk("mid.pause_after", {31'd0, o_pause}, 32'd0);
        chk("mid.rd0_after", o_rd[31:0], RF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
